pin_input_debouncer: RTL and testbench
======================================

Name: pin_input_debouncer

Overview:
- Input-direction counterpart to the board's LED/pin output logic. It samples N TinyFPGA A1 header pins as inputs (buttons/switches), synchronises and debounces them, and emits clean levels, one-cycle edge pulses and sticky press flags.
- Runs on the OSCH internal oscillator clock (2.08 MHz nominal).
- Sits between the top-level inout pins (driven 1'bz) and user logic.

Parameters:
- N_CH, 3, number of input channels.
- SYNC_STAGES, 2, synchroniser flops per channel; legal range 2..4.
- DEBOUNCE_CYCLES, 20800, stable-sample count required to commit a change (~10 ms at 2.08 MHz); must be >= 2.
- ACTIVE_LOW, 1, 1 means a low pin level is "pressed" (pull-up buttons); 0 means a high pin level is "pressed".
- LONG_CYCLES, 2080000, hold time for a long press (~1 s); used only with LONG_PRESS_EN.

Ports:
- clk  input  1  OSCH clock
- rst_n  input  1  asynchronous active-low reset
- pin_in  input  N_CH  raw asynchronous pin levels
- level  output  N_CH  debounced logical state, 1 = pressed
- press  output  N_CH  one-cycle pulse when level goes 0->1
- release  output  N_CH  one-cycle pulse when level goes 1->0
- evt_pending  output  N_CH  sticky press flag
- evt_clr  input  N_CH  per-bit clear for evt_pending
- long_press  output  N_CH  one-cycle long-press pulse

Behaviour:
- Reset (async assert, sync release is the integrator's concern):
  - All outputs 0.
  - Synchroniser flops preset to the inactive pin level (1 if ACTIVE_LOW, else 0).
  - Counters 0; every FSM in S_LOW.
- Logical sample: s = sync_out XOR ACTIVE_LOW.
- Per-channel FSM, states S_LOW, S_CHK_HI, S_HIGH, S_CHK_LO:
  - S_LOW: if s=1, go to S_CHK_HI with cnt<=0.
  - S_CHK_HI:
    - if s=0, go to S_LOW with cnt<=0 (glitch rejected, no pulse);
    - else if cnt==DEBOUNCE_CYCLES-1, go to S_HIGH, level<=1, press<=1 for one cycle;
    - else cnt<=cnt+1.
  - S_HIGH and S_CHK_LO mirror S_LOW and S_CHK_HI, with the release pulse and level<=0.
- Latency: from the first synchronised change, level toggles exactly DEBOUNCE_CYCLES+1 clocks later. From the pin, add SYNC_STAGES.
- A glitch lasting DEBOUNCE_CYCLES or fewer synchronised cycles produces no output change.
- Counter width is $clog2(DEBOUNCE_CYCLES). The counter never wraps, because it is cleared on every state exit.
- press and release are mutually exclusive per channel and never asserted in consecutive cycles (the minimum gap is DEBOUNCE_CYCLES+1).
- Outputs (level, pulses, evt_pending) are registered; there is no combinational path from pin_in to any output.
- evt_pending[i]:
  - set on press[i];
  - cleared when evt_clr[i]=1;
  - if set and clear happen in the same cycle, set wins (no lost events);
  - evt_clr[i] with no pending event has no effect.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- Reset mid-check: the FSM returns to S_LOW, level=0, and no pulse is emitted on release of reset even if the pin is held active. The press is then re-qualified in full.

Optional Feature:
- Macro: PIN_INPUT_LONG_PRESS_EN.
- Defined:
  - A per-channel hold counter of width $clog2(LONG_CYCLES) runs while in S_HIGH.
  - When it reaches LONG_CYCLES-1, long_press[i] pulses for one cycle and the counter saturates (one pulse per hold).
  - The counter clears on leaving S_HIGH and on reset.
- Undefined: the long_press port is still present but tied to 0, and no hold counter logic is built.

Decomposition:
- Package pin_input_pkg holds:
  - state enum deb_state_t {S_LOW, S_CHK_HI, S_HIGH, S_CHK_LO};
  - a width helper constant function;
  - the default timing constants for 2.08 MHz.
- One natural sub-module, debounce_channel, containing the synchroniser, FSM, debounce counter, edge pulses, sticky flag and optional hold counter.
- The top generates N_CH instances.

Test Plan (DEBOUNCE_CYCLES=8, SYNC_STAGES=2, LONG_CYCLES=32, ACTIVE_LOW=1):
- Drive pin_in[0] low for 5 clocks, then high -> level[0] stays 0, press never asserts, evt_pending[0]=0.
- Drive pin_in[0] low and hold -> level[0]=1 and press[0]=1 for exactly one clock, 11 clocks after the pin edge (2+9); evt_pending[0]=1.
- Release pin_in[0] high after the committed press -> release[0] pulses once 11 clocks later; level[0]=0; evt_pending[0] remains 1.
- Assert evt_clr[1] in the same cycle as press[1] -> evt_pending[1]=1. Assert evt_clr[1] one clock later -> evt_pending[1]=0.
- Drive pin_in[2] low, then deassert rst_n for 1 clock at 5 clocks into the check -> all outputs 0. With the pin still low, the next press[2] arrives 11 clocks after rst_n rises.
- With PIN_INPUT_LONG_PRESS_EN, hold pin_in[0] low -> long_press[0] pulses once 32 clocks after level[0] rises, with no repeat. Without the macro, long_press stays 0 throughout.

Source files
------------

// File: rtl/pin_input_pkg.sv
// Shared types and defaults for the pin input debouncer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pin_input_pkg;

  // Per-channel debounce FSM states: two stable levels, each with a qualification state.
  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_CHK_HI = 2'd1,
    S_HIGH   = 2'd2,
    S_CHK_LO = 2'd3
  } deb_state_t;

  // Default timing for the OSCH oscillator at 2.08 MHz nominal.
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 20800;    // ~10 ms
  localparam int unsigned DEF_LONG_CYCLES     = 2080000;  // ~1 s

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchroniser, debounce FSM, edge pulses, sticky press flag, optional long-press (PIN_INPUT_LONG_PRESS_EN).
// Latency: level/press/release_pulse change SYNC_STAGES + DEBOUNCE_CYCLES + 1 clocks after a stable pin change.
// Backpressure: none; pulses are fire-and-forget, evt_pending holds until evt_clr.
module debounce_channel
  import pin_input_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  input  logic evt_clr,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic evt_pending,
  output logic long_press
);

  localparam int unsigned CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Pin level that means "not pressed"; the synchroniser resets to it so
  // leaving reset never looks like an edge.
  localparam logic IDLE_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;

  // Elaboration-time parameter sanity.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debounce_channel: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("debounce_channel: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("debounce_channel: LONG_CYCLES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  deb_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   rel_q, rel_d;
  logic                   evt_q;

  // Metastability synchroniser, preset to the idle pin level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE_LVL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
    end
  end

  // Logical sample: 1 = pressed regardless of pin polarity.
  assign s = sync_q[SYNC_STAGES-1] ^ IDLE_LVL;

  // FSM, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Next-state: a change is committed only after DEBOUNCE_CYCLES consecutive agreeing samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      S_LOW: begin
        if (s) begin
          state_d = S_CHK_HI;
          cnt_d   = '0;
        end
      end
      S_CHK_HI: begin
        if (!s) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (!s) begin
          state_d = S_CHK_LO;
          cnt_d   = '0;
        end
      end
      S_CHK_LO: begin
        if (s) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // Sticky press flag; a press in the same cycle as a clear wins so no event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= 1'b0;
    end else begin
      evt_q <= press_d | (evt_q & ~evt_clr);
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = rel_q;
  assign evt_pending   = evt_q;

`ifdef PIN_INPUT_LONG_PRESS_EN
  localparam int unsigned LONG_W = cnt_width(LONG_CYCLES);
  localparam logic [LONG_W-1:0] HOLD_LAST = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] hold_q;
  logic              hold_done_q;
  logic              long_q;

  // Hold timer: counts while committed high, fires once and then saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else if (state_q == S_HIGH) begin
      long_q <= 1'b0;
      if (!hold_done_q) begin
        if (hold_q == HOLD_LAST) begin
          long_q      <= 1'b1;
          hold_done_q <= 1'b1;
        end else begin
          hold_q <= hold_q + 1'b1;
        end
      end
    end else begin
      hold_q      <= '0;
      hold_done_q <= 1'b0;
      long_q      <= 1'b0;
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/pin_input_debouncer.sv
// N_CH independent pin debouncers (clean level, press/release pulses, sticky flag; long press under PIN_INPUT_LONG_PRESS_EN).
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES + 1 clocks from a stable pin change to level/press/release_pulse.
// Backpressure: none; evt_pending bits hold until cleared by the matching evt_clr bit.
module pin_input_debouncer
  import pin_input_pkg::*;
#(
  parameter int unsigned N_CH            = 3,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pin_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] evt_pending,
  input  logic [N_CH-1:0] evt_clr,
  output logic [N_CH-1:0] long_press
);

  // One fully independent channel per pin.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .pin_in        (pin_in[i]),
      .evt_clr       (evt_clr[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .evt_pending   (evt_pending[i]),
      .long_press    (long_press[i])
    );
  end

endmodule

// File: tb/tb_pin_input_debouncer.sv
// Self-checking bench for pin_input_debouncer with short timing constants.
// Latency: n/a.
// Backpressure: n/a.
module tb_pin_input_debouncer;

  localparam int N   = 3;
  localparam int DB  = 8;
  localparam int SS  = 2;
  localparam int LC  = 32;
  localparam int LAT = SS + DB + 1;  // pin change to level/pulse, in clocks

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] pin_in;
  logic [N-1:0] evt_clr;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] release_pulse;
  logic [N-1:0] evt_pending;
  logic [N-1:0] long_press;

  pin_input_debouncer #(
    .N_CH            (N),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DB),
    .ACTIVE_LOW      (1'b1),
    .LONG_CYCLES     (LC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pin_in        (pin_in),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .evt_pending   (evt_pending),
    .evt_clr       (evt_clr),
    .long_press    (long_press)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int ch;
    int kind;
    int at;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic expect_evt(input int ch, input int kind, input int at);
    exp_t e;
    e.ch   = ch;
    e.kind = kind;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Monitor: every observed pulse must match a scheduled entry at its exact cycle.
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int ch = 0; ch < N; ch++) begin
      for (int k = 0; k < 3; k++) begin
        logic bitv;
        int   idx;
        bitv = (k == K_PRESS) ? press[ch] : (k == K_REL) ? release_pulse[ch] : long_press[ch];
        if (bitv === 1'b1) begin
          idx = -1;
          for (int j = 0; j < sb.size(); j++) begin
            if (idx < 0 && sb[j].ch == ch && sb[j].kind == k) idx = j;
          end
          if (idx < 0) begin
            chk($sformatf("unexpected_k%0d_ch%0d@%0d", k, ch, cyc), 1, 0);
          end else begin
            chk($sformatf("evt_cycle_k%0d_ch%0d", k, ch), cyc, sb[idx].at);
            sb.delete(idx);
            if (k == K_PRESS) chk($sformatf("level_at_press_ch%0d", ch), level[ch], 1);
            if (k == K_REL)   chk($sformatf("level_at_rel_ch%0d", ch), level[ch], 0);
          end
        end
      end
    end
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].at < cyc) begin
        chk($sformatf("missed_k%0d_ch%0d_at%0d", sb[j].kind, sb[j].ch, sb[j].at), 0, 1);
        sb.delete(j);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    pin_in  = '1;
    evt_clr = '0;
    repeat (3) @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_press", press, 0);
    chk("rst_release", release_pulse, 0);
    chk("rst_evt_pending", evt_pending, 0);
    chk("rst_long", long_press, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Short glitch: 5 clocks active.
    pin_in[0] = 1'b0;
    repeat (5) @(negedge clk);
    pin_in[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch5_level", level[0], 0);
    chk("glitch5_pending", evt_pending[0], 0);

    // Boundary: exactly DB active samples is still rejected.
    pin_in[0] = 1'b0;
    repeat (DB) @(negedge clk);
    pin_in[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitchDB_level", level[0], 0);
    chk("glitchDB_pending", evt_pending[0], 0);

    // Boundary: DB+1 active samples commits a press, then a release.
    expect_evt(0, K_PRESS, cyc + LAT);
    pin_in[0] = 1'b0;
    repeat (DB + 1) @(negedge clk);
    expect_evt(0, K_REL, cyc + LAT);
    pin_in[0] = 1'b1;
    repeat (25) @(negedge clk);
    chk("min_press_level", level[0], 0);
    chk("min_press_pending", evt_pending[0], 1);

    // Clear the flag, then a clear with nothing pending.
    evt_clr[0] = 1'b1;
    @(negedge clk);
    evt_clr[0] = 1'b0;
    @(negedge clk);
    chk("clr0_pending", evt_pending[0], 0);
    evt_clr[0] = 1'b1;
    @(negedge clk);
    evt_clr[0] = 1'b0;
    @(negedge clk);
    chk("clr0_idle_pending", evt_pending[0], 0);

    // Long hold on channel 0.
    expect_evt(0, K_PRESS, cyc + LAT);
`ifdef PIN_INPUT_LONG_PRESS_EN
    expect_evt(0, K_LONG, cyc + LAT + LC);
`endif
    pin_in[0] = 1'b0;
    repeat (LAT + LC + 15) @(negedge clk);
    chk("hold_level", level[0], 1);
    chk("hold_pending", evt_pending[0], 1);
    expect_evt(0, K_REL, cyc + LAT);
    pin_in[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("hold_rel_level", level[0], 0);
    chk("hold_rel_pending_kept", evt_pending[0], 1);

    // Clear colliding with press on channel 1: set wins, next-cycle clear takes effect.
    begin
      int p;
      p = cyc;
      expect_evt(1, K_PRESS, p + LAT);
      pin_in[1] = 1'b0;
      repeat (LAT - 1) @(negedge clk);
      evt_clr[1] = 1'b1;
      @(posedge clk);
      #1;
      chk("clr1_same_cycle_pending", evt_pending[1], 1);
      @(negedge clk);
      @(posedge clk);
      #1;
      chk("clr1_next_cycle_pending", evt_pending[1], 0);
      @(negedge clk);
      evt_clr[1] = 1'b0;
      chk("ch0_pending_independent", evt_pending[0], 1);
    end
    expect_evt(1, K_REL, cyc + LAT);
    pin_in[1] = 1'b1;
    repeat (20) @(negedge clk);

    // Simultaneous press/release on channels 0 and 1.
    expect_evt(0, K_PRESS, cyc + LAT);
    expect_evt(1, K_PRESS, cyc + LAT);
    pin_in[1:0] = 2'b00;
    repeat (LAT + 3) @(negedge clk);
    chk("simul_level", level, 3'b011);
    expect_evt(0, K_REL, cyc + LAT);
    expect_evt(1, K_REL, cyc + LAT);
    pin_in[1:0] = 2'b11;
    repeat (LAT + 3) @(negedge clk);
    chk("simul_rel_level", level, 0);

    // Reset in the middle of qualifying a press on channel 2.
    pin_in[2] = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_pending", evt_pending, 3'b011);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_level", level, 0);
    chk("midrst_pending", evt_pending, 0);
    chk("midrst_pulses", {press, release_pulse, long_press}, 0);
    rst_n = 1'b1;
    expect_evt(2, K_PRESS, cyc + LAT);
    repeat (LAT + 5) @(negedge clk);
    chk("post_rst_level", level[2], 1);
    chk("post_rst_pending", evt_pending[2], 1);
    expect_evt(2, K_REL, cyc + LAT);
    pin_in[2] = 1'b1;
    repeat (LAT + 5) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
